// File: rtl/program_store.sv
// Instruction store feeding the datapath: loads a program over a valid/ready byte
// stream, then serves instruction words combinationally from the datapath PC.
module program_store #(
  parameter int         ADDR_W   = 8,
  parameter int         DEPTH    = 256,
  parameter logic [7:0] NOP_CODE = 8'h00
) (
  input  logic              _CLK,
  input  logic              RESET,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              load_done,
  input  logic              run_start,
  input  logic              run_stop,
  input  logic [ADDR_W-1:0] PC,
  output logic [7:0]        instruction,
  output logic              cpu_enable,
  output logic [ADDR_W:0]   prog_len,
  output logic              overflow,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);

  state_t          state_q;
  state_t          state_d;
  logic [ADDR_W:0] prog_len_q;
  logic            overflow_q;
  logic [7:0]      mem [DEPTH];
  logic            transfer;

  assign load_ready = (state_q == LOAD) && (prog_len_q < LEN_FULL);
  assign transfer   = load_valid && load_ready;
  assign cpu_enable = (state_q == RUN);
  assign prog_len   = prog_len_q;
  assign overflow   = overflow_q;
  assign state      = state_q;

  // load_start outranks run_start in IDLE; run_stop is the only exit from RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_start)
          state_d = LOAD;
        else if (run_start && (prog_len_q != '0))
          state_d = RUN;
      end
      LOAD: begin
        if (load_done)
          state_d = IDLE;
      end
      RUN: begin
        if (run_stop)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bytes at or beyond prog_len are stale leftovers of an older program
  always_comb begin
    instruction = NOP_CODE;
    if ((state_q == RUN) && ({1'b0, PC} < prog_len_q))
      instruction = mem[PC];
  end

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && load_start) begin
        prog_len_q <= '0;
        overflow_q <= 1'b0;
      end else if (transfer) begin
        prog_len_q <= prog_len_q + LEN_ONE;
      end else if ((state_q == LOAD) && load_valid) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge _CLK) begin
    if (transfer && !RESET)
      mem[prog_len_q[ADDR_W-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_program_store.sv
// Bench for program_store: vector table plus a full-memory sequence, with expected
// post-edge outputs queued at drive time and compared one cycle later.
module tb_program_store;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic       load_done = 1'b0;
  logic       run_start = 1'b0;
  logic       run_stop = 1'b0;
  logic [7:0] pc = 8'h00;
  logic [7:0] instruction;
  logic       cpu_enable;
  logic [8:0] prog_len;
  logic       overflow;
  logic [1:0] state;

  int vectors_applied = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic       rst;
    logic       ls;
    logic       lv;
    logic [7:0] ld;
    logic       done;
    logic       rs;
    logic       stp;
    logic [7:0] pc;
    logic [1:0] e_state;
    logic [7:0] e_instr;
    logic       e_en;
    logic [8:0] e_len;
    logic       e_rdy;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  program_store dut (
    ._CLK        (clk),
    .RESET       (rst_in),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .run_start   (run_start),
    .run_stop    (run_stop),
    .PC          (pc),
    .instruction (instruction),
    .cpu_enable  (cpu_enable),
    .prog_len    (prog_len),
    .overflow    (overflow),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string tag, logic rst, logic ls, logic lv, logic [7:0] ld,
                              logic done, logic rs, logic stp, logic [7:0] p,
                              logic [1:0] st, logic [7:0] ins, logic en, logic [8:0] len,
                              logic rdy, logic ovf);
    vec_t v;
    v.tag = tag; v.rst = rst; v.ls = ls; v.lv = lv; v.ld = ld; v.done = done;
    v.rs = rs; v.stp = stp; v.pc = p; v.e_state = st; v.e_instr = ins; v.e_en = en;
    v.e_len = len; v.e_rdy = rdy; v.e_ovf = ovf;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_in     = v.rst;
    load_start = v.ls;
    load_valid = v.lv;
    load_data  = v.ld;
    load_done  = v.done;
    run_start  = v.rs;
    run_stop   = v.stp;
    pc         = v.pc;
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input string field, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    vectors_applied++;
    chk(v.tag, "state",       int'(state),       int'(v.e_state));
    chk(v.tag, "instruction", int'(instruction), int'(v.e_instr));
    chk(v.tag, "cpu_enable",  int'(cpu_enable),  int'(v.e_en));
    chk(v.tag, "prog_len",    int'(prog_len),    int'(v.e_len));
    chk(v.tag, "load_ready",  int'(load_ready),  int'(v.e_rdy));
    chk(v.tag, "overflow",    int'(overflow),    int'(v.e_ovf));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0)
      checkOutput(exp_q.pop_front());
  end

  initial begin
    //                 rst ls lv ld     dn rs sp pc     st   ins    en len   rdy ovf
    tbl.push_back(mk("reset",    1,0,0,8'h00, 0,0,0,8'h00, 2'd0,8'h00, 0,9'd0, 0,0));
    tbl.push_back(mk("run_empty",0,0,0,8'h00, 0,1,0,8'h00, 2'd0,8'h00, 0,9'd0, 0,0));
    tbl.push_back(mk("ld_start", 0,1,0,8'h00, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    tbl.push_back(mk("ld_b0",    0,0,1,8'h12, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd1, 1,0));
    tbl.push_back(mk("ld_b1",    0,0,1,8'h34, 0,1,1,8'h00, 2'd1,8'h00, 0,9'd2, 1,0));
    tbl.push_back(mk("ld_b2",    0,0,1,8'h56, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd3, 1,0));
    tbl.push_back(mk("ld_done",  0,0,0,8'h00, 1,0,0,8'h00, 2'd0,8'h00, 0,9'd3, 0,0));
    tbl.push_back(mk("run_pc0",  0,0,0,8'h00, 0,1,0,8'h00, 2'd2,8'h12, 1,9'd3, 0,0));
    tbl.push_back(mk("run_pc1",  0,0,0,8'h00, 0,0,0,8'h01, 2'd2,8'h34, 1,9'd3, 0,0));
    tbl.push_back(mk("run_pc2",  0,0,0,8'h00, 0,0,0,8'h02, 2'd2,8'h56, 1,9'd3, 0,0));
    tbl.push_back(mk("run_pc3",  0,0,0,8'h00, 0,0,0,8'h03, 2'd2,8'h00, 1,9'd3, 0,0));
    tbl.push_back(mk("run_stop", 0,0,0,8'h00, 0,0,1,8'h00, 2'd0,8'h00, 0,9'd3, 0,0));
    tbl.push_back(mk("ls_rs",    0,1,0,8'h00, 0,1,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    tbl.push_back(mk("xfer_done",0,0,1,8'hAA, 1,0,0,8'h00, 2'd0,8'h00, 0,9'd1, 0,0));
    tbl.push_back(mk("run_aa",   0,0,0,8'h00, 0,1,0,8'h00, 2'd2,8'hAA, 1,9'd1, 0,0));
    tbl.push_back(mk("run_stale",0,0,0,8'h00, 0,0,0,8'h01, 2'd2,8'h00, 1,9'd1, 0,0));
    tbl.push_back(mk("run_ls",   0,1,0,8'h00, 0,0,0,8'h00, 2'd2,8'hAA, 1,9'd1, 0,0));
    tbl.push_back(mk("stop_prio",0,1,0,8'h00, 0,1,1,8'h00, 2'd0,8'h00, 0,9'd1, 0,0));
    tbl.push_back(mk("mid_ls",   0,1,0,8'h00, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    tbl.push_back(mk("mid_b0",   0,0,1,8'h01, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd1, 1,0));
    tbl.push_back(mk("mid_b1",   0,0,1,8'h02, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd2, 1,0));
    tbl.push_back(mk("mid_rst",  1,0,1,8'h03, 0,0,0,8'h00, 2'd0,8'h00, 0,9'd0, 0,0));
    tbl.push_back(mk("mid_run",  0,0,0,8'h00, 0,1,0,8'h00, 2'd0,8'h00, 0,9'd0, 0,0));
    tbl.push_back(mk("rr_ls",    0,1,0,8'h00, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    tbl.push_back(mk("rr_b0",    0,0,1,8'h11, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd1, 1,0));
    tbl.push_back(mk("rr_done",  0,0,0,8'h00, 1,0,0,8'h00, 2'd0,8'h00, 0,9'd1, 0,0));
    tbl.push_back(mk("rr_run",   0,0,0,8'h00, 0,1,0,8'h00, 2'd2,8'h11, 1,9'd1, 0,0));
    tbl.push_back(mk("rr_rst",   1,0,0,8'h00, 0,0,0,8'h00, 2'd0,8'h00, 0,9'd0, 0,0));
    tbl.push_back(mk("rl_ls",    0,1,0,8'h00, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    tbl.push_back(mk("rl_a0",    0,0,1,8'hA0, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd1, 1,0));
    tbl.push_back(mk("rl_a1",    0,0,1,8'hA1, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd2, 1,0));
    tbl.push_back(mk("rl_a2",    0,0,1,8'hA2, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd3, 1,0));
    tbl.push_back(mk("rl_a3",    0,0,1,8'hA3, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd4, 1,0));
    tbl.push_back(mk("rl_done1", 0,0,0,8'h00, 1,0,0,8'h00, 2'd0,8'h00, 0,9'd4, 0,0));
    tbl.push_back(mk("rl_ls2",   0,1,0,8'h00, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    tbl.push_back(mk("rl_b0",    0,0,1,8'hB0, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd1, 1,0));
    tbl.push_back(mk("rl_b1",    0,0,1,8'hB1, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd2, 1,0));
    tbl.push_back(mk("rl_done2", 0,0,0,8'h00, 1,0,0,8'h00, 2'd0,8'h00, 0,9'd2, 0,0));
    tbl.push_back(mk("rl_pc3",   0,0,0,8'h00, 0,1,0,8'h03, 2'd2,8'h00, 1,9'd2, 0,0));
    tbl.push_back(mk("rl_pc1",   0,0,0,8'h00, 0,0,0,8'h01, 2'd2,8'hB1, 1,9'd2, 0,0));
    tbl.push_back(mk("rl_pc0",   0,0,0,8'h00, 0,0,0,8'h00, 2'd2,8'hB0, 1,9'd2, 0,0));
    tbl.push_back(mk("rl_stop",  0,0,0,8'h00, 0,0,1,8'h00, 2'd0,8'h00, 0,9'd2, 0,0));

    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i]);

    // Fill the whole memory with value = address, then push two bytes past full
    applyStimulus(mk("full_ls", 0,1,0,8'h00, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    for (int i = 0; i < 256; i++)
      applyStimulus(mk($sformatf("full_b%0d", i), 0,0,1,8'(i), 0,0,0,8'h00,
                       2'd1,8'h00, 0,9'(i+1), (i < 255) ? 1'b1 : 1'b0, 0));
    applyStimulus(mk("ovf_1",    0,0,1,8'hEE, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd256, 0,1));
    applyStimulus(mk("ovf_2",    0,0,1,8'hEF, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd256, 0,1));
    applyStimulus(mk("full_done",0,0,0,8'h00, 1,0,0,8'h00, 2'd0,8'h00, 0,9'd256, 0,1));
    applyStimulus(mk("full_ff",  0,0,0,8'h00, 0,1,0,8'hFF, 2'd2,8'hFF, 1,9'd256, 0,1));
    applyStimulus(mk("full_80",  0,0,0,8'h00, 0,0,0,8'h80, 2'd2,8'h80, 1,9'd256, 0,1));
    applyStimulus(mk("full_stop",0,0,0,8'h00, 0,0,1,8'hFF, 2'd0,8'h00, 0,9'd256, 0,1));
    applyStimulus(mk("ovf_clear",0,1,0,8'h00, 0,0,0,8'h00, 2'd1,8'h00, 0,9'd0, 1,0));
    applyStimulus(mk("end_done", 0,0,0,8'h00, 1,0,0,8'h00, 2'd0,8'h00, 0,9'd0, 0,0));

    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0; load_done = 1'b0;
    run_start = 1'b0; run_stop = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
